// File: rtl/odd_acc_pkg.sv
// Shared definitions for the odd accumulator: reduction mode codes and FSM state encoding.
package odd_acc_pkg;

  // Reduction modes, sampled together with N on the first strobe of a frame.
  localparam logic [1:0] MODE_CNT_ODD  = 2'b00;
  localparam logic [1:0] MODE_SUM_ODD  = 2'b01;
  localparam logic [1:0] MODE_MAX_ODD  = 2'b10;
  localparam logic [1:0] MODE_CNT_EVEN = 2'b11;

  // Frame collection states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_DONE    = 2'b10
  } state_t;

  // A word is odd when its least significant bit is set.
  function automatic logic is_odd(input logic lsb);
    return lsb;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous strobe followed by a rising-edge
// detector that yields a single-cycle pulse in the clk domain.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Shift the async strobe through the synchroniser chain and remember the last stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Both terms come straight from flops, so the pulse is glitch-free and one cycle wide.
  assign pulse = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/odd_accumulator.sv
// Frame-based odd/even reducer: collects N strobed words and reduces them by a
// mode chosen at frame start (count odd, sum odd with saturation, max odd, count even).
module odd_accumulator
  import odd_acc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int CNT_W       = 8,
  parameter int ACC_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] integers,
  input  logic [CNT_W-1:0]  N,
  input  logic              latch_in,
  input  logic [1:0]        mode,
  output logic [ACC_W-1:0]  out_value,
  output logic              ready,
  output logic              busy,
  output logic              overflow
);

  logic              stb_s;
  state_t            state_r;
  logic [CNT_W-1:0]  n_r;
  logic [CNT_W-1:0]  count_r;
  logic [1:0]        mode_r;
  logic [ACC_W-1:0]  acc_r;
  logic [ACC_W-1:0]  out_value_r;
  logic              ready_r;
  logic              busy_r;
  logic              overflow_r;

  logic              collecting_s;
  logic              start_s;
  logic [1:0]        step_mode_s;
  logic [ACC_W-1:0]  base_acc_s;
  logic [ACC_W-1:0]  word_ext_s;
  logic [ACC_W:0]    sum_s;
  logic              word_odd_s;
  logic [ACC_W-1:0]  next_acc_s;
  logic              step_ovf_s;
  logic [CNT_W-1:0]  count_next_s;
  logic              last_s;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_detect (
    .clk      (clk),
    .reset    (reset),
    .async_in (latch_in),
    .pulse    (stb_s)
  );

  // Frame control: a frame either continues (COLLECT) or a new one starts from IDLE/DONE,
  // in which case the live N/mode inputs apply and the accumulator starts from zero.
  always_comb begin
    collecting_s = (state_r == ST_COLLECT);
    start_s      = stb_s && !collecting_s && (N != {CNT_W{1'b0}});
    if (collecting_s) begin
      step_mode_s  = mode_r;
      base_acc_s   = acc_r;
      count_next_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      last_s       = (count_next_s == n_r);
    end else begin
      step_mode_s  = mode;
      base_acc_s   = {ACC_W{1'b0}};
      count_next_s = {{(CNT_W-1){1'b0}}, 1'b1};
      last_s       = (N == {{(CNT_W-1){1'b0}}, 1'b1});
    end
  end

  // One reduction step of the current word onto the running accumulator.
  always_comb begin
    word_ext_s = ACC_W'(integers);
    word_odd_s = is_odd(integers[0]);
    sum_s      = {1'b0, base_acc_s} + {1'b0, word_ext_s};
    next_acc_s = base_acc_s;
    step_ovf_s = 1'b0;
    case (step_mode_s)
      MODE_CNT_ODD: begin
        if (word_odd_s) begin
          next_acc_s = base_acc_s + {{(ACC_W-1){1'b0}}, 1'b1};
        end else begin
          next_acc_s = base_acc_s;
        end
      end
      MODE_SUM_ODD: begin
        if (word_odd_s && sum_s[ACC_W]) begin
          next_acc_s = {ACC_W{1'b1}};
          step_ovf_s = 1'b1;
        end else if (word_odd_s) begin
          next_acc_s = sum_s[ACC_W-1:0];
        end else begin
          next_acc_s = base_acc_s;
        end
      end
      MODE_MAX_ODD: begin
        if (word_odd_s && (word_ext_s > base_acc_s)) begin
          next_acc_s = word_ext_s;
        end else begin
          next_acc_s = base_acc_s;
        end
      end
      MODE_CNT_EVEN: begin
        if (!word_odd_s) begin
          next_acc_s = base_acc_s + {{(ACC_W-1){1'b0}}, 1'b1};
        end else begin
          next_acc_s = base_acc_s;
        end
      end
      default: begin
        next_acc_s = base_acc_s;
        step_ovf_s = 1'b0;
      end
    endcase
  end

  // Frame FSM with counter, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      n_r         <= {CNT_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      mode_r      <= MODE_CNT_ODD;
      acc_r       <= {ACC_W{1'b0}};
      out_value_r <= {ACC_W{1'b0}};
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_s) begin
            n_r        <= N;
            mode_r     <= mode;
            count_r    <= count_next_s;
            acc_r      <= next_acc_s;
            overflow_r <= step_ovf_s;
            if (last_s) begin
              state_r     <= ST_DONE;
              out_value_r <= next_acc_s;
              ready_r     <= 1'b1;
              busy_r      <= 1'b0;
            end else begin
              state_r <= ST_COLLECT;
              ready_r <= 1'b0;
              busy_r  <= 1'b1;
            end
          end
        end
        ST_COLLECT: begin
          if (stb_s) begin
            count_r    <= count_next_s;
            acc_r      <= next_acc_s;
            overflow_r <= overflow_r | step_ovf_s;
            if (last_s) begin
              state_r     <= ST_DONE;
              out_value_r <= next_acc_s;
              ready_r     <= 1'b1;
              busy_r      <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign out_value = out_value_r;
  assign ready     = ready_r;
  assign busy      = busy_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_odd_accumulator.sv
// Self-checking bench: a 16-bit and an 8-bit accumulator share the same stimulus and
// are both compared to a frame-level reference model.
module tb_odd_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  integers;
  logic [7:0]  N;
  logic        latch_in;
  logic [1:0]  mode;
  logic [15:0] ov16;
  logic        rdy16, bsy16, ovf16;
  logic [7:0]  ov8;
  logic        rdy8, bsy8, ovf8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  odd_accumulator dut16 (
    .clk(clk), .reset(reset), .integers(integers), .N(N), .latch_in(latch_in),
    .mode(mode), .out_value(ov16), .ready(rdy16), .busy(bsy16), .overflow(ovf16)
  );

  odd_accumulator #(.ACC_W(8)) dut8 (
    .clk(clk), .reset(reset), .integers(integers), .N(N), .latch_in(latch_in),
    .mode(mode), .out_value(ov8), .ready(rdy8), .busy(bsy8), .overflow(ovf8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: reduce a whole frame from the list of words with plain arithmetic.
  function automatic longint model(input int md, input int words[$], input int accw,
                                   output bit ovf);
    longint r = 0;
    longint maxv = (longint'(1) << accw) - 1;
    ovf = 1'b0;
    foreach (words[i]) begin
      case (md)
        0: if (words[i] % 2 == 1) r++;
        1: if (words[i] % 2 == 1) r += words[i];
        2: if (words[i] % 2 == 1 && words[i] > r) r = words[i];
        default: if (words[i] % 2 == 0) r++;
      endcase
    end
    if (r > maxv) begin
      r = maxv;
      ovf = 1'b1;
    end
    return r;
  endfunction

  // One strobe: data and strobe high for 5 cycles, strobe low for 5 cycles.
  task automatic send_word(input int w);
    @(negedge clk);
    integers = 8'(w);
    latch_in = 1'b1;
    repeat (5) @(negedge clk);
    latch_in = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic check_result(input string tag, input int md, input int words[$]);
    bit o16, o8;
    longint e16, e8;
    e16 = model(md, words, 16, o16);
    e8  = model(md, words, 8, o8);
    check({tag, ".ready16"}, 32'(rdy16), 32'd1);
    check({tag, ".ready8"},  32'(rdy8),  32'd1);
    check({tag, ".busy16"},  32'(bsy16), 32'd0);
    check({tag, ".busy8"},   32'(bsy8),  32'd0);
    check({tag, ".value16"}, 32'(ov16),  32'(e16));
    check({tag, ".value8"},  32'(ov8),   32'(e8));
    check({tag, ".ovf16"},   32'(ovf16), 32'(o16));
    check({tag, ".ovf8"},    32'(ovf8),  32'(o8));
  endtask

  task automatic run_frame(input string tag, input int md, input int words[$]);
    @(negedge clk);
    N    = 8'(words.size());
    mode = 2'(md);
    foreach (words[i]) begin
      send_word(words[i]);
      if (i == 0 && words.size() > 1) begin
        check({tag, ".first_ready"}, 32'(rdy16), 32'd0);
        check({tag, ".first_busy"},  32'(bsy16), 32'd1);
      end
    end
    check_result(tag, md, words);
  endtask

  initial begin
    int seq[$];
    int w[$];
    reset    = 1'b1;
    integers = 8'd0;
    N        = 8'd0;
    latch_in = 1'b0;
    mode     = 2'b00;
    repeat (3) @(negedge clk);
    check("rst.value16", 32'(ov16), 32'd0);
    check("rst.ready",   32'(rdy16), 32'd0);
    check("rst.busy",    32'(bsy16), 32'd0);
    check("rst.ovf",     32'(ovf16), 32'd0);
    reset = 1'b0;

    // N=0 strobes are ignored, then a single-word frame.
    N = 8'd0;
    mode = 2'b01;
    for (int i = 0; i < 4; i++) begin
      send_word(i + 3);
      check("n0.busy",  32'(bsy16), 32'd0);
      check("n0.ready", 32'(rdy16), 32'd0);
    end
    run_frame("n1", 2, '{7});
    check("n1.value7", 32'(ov16), 32'd7);

    // Words 1..11 in all four modes, back to back.
    seq = {};
    for (int i = 1; i <= 11; i++) seq.push_back(i);
    run_frame("sum11", 1, seq);
    check("sum11.const", 32'(ov16), 32'd36);
    run_frame("cnt11", 0, seq);
    check("cnt11.const", 32'(ov16), 32'd6);
    run_frame("max11", 2, seq);
    check("max11.const", 32'(ov16), 32'd11);
    run_frame("even11", 3, seq);
    check("even11.const", 32'(ov16), 32'd5);

    // Saturation on the 8-bit instance, cleared by the next frame.
    run_frame("sat", 1, '{255, 255, 1});
    check("sat.ovf8_const", 32'(ovf8), 32'd1);
    check("sat.val8_const", 32'(ov8), 32'd255);
    run_frame("clr", 1, '{1, 2});
    check("clr.ovf8_const", 32'(ovf8), 32'd0);

    // Reset mid-frame, then a fresh frame.
    @(negedge clk);
    N = 8'd5;
    mode = 2'b01;
    for (int i = 0; i < 3; i++) send_word(3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst.value", 32'(ov16),  32'd0);
    check("midrst.ready", 32'(rdy16), 32'd0);
    check("midrst.busy",  32'(bsy16), 32'd0);
    check("midrst.ovf",   32'(ovf16), 32'd0);
    run_frame("after_rst", 1, '{3, 3, 3, 3, 3});
    check("after_rst.const", 32'(ov16), 32'd15);

    // No odd words in max mode; N changed mid-frame must be ignored.
    @(negedge clk);
    N = 8'd4;
    mode = 2'b10;
    send_word(2);
    send_word(4);
    N = 8'd3;
    mode = 2'b01;
    send_word(6);
    check("nchg.ready_early", 32'(rdy16), 32'd0);
    check("nchg.busy_early",  32'(bsy16), 32'd1);
    send_word(8);
    check_result("nchg", 2, '{2, 4, 6, 8});

    // Randomized frames.
    for (int f = 0; f < 8; f++) begin
      int n, md;
      n  = $urandom_range(1, 10);
      md = $urandom_range(0, 3);
      w  = {};
      for (int i = 0; i < n; i++) w.push_back($urandom_range(0, 255));
      run_frame($sformatf("rnd%0d", f), md, w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
